// File: rtl/mult_unit_if.sv
// mult_unit_if: controller-to-multiplier handshake and result bus
interface mult_unit_if #(parameter int WIDTH = 32);
    logic             multstart;
    logic             multsgn;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             lohi;
    logic [WIDTH-1:0] multresult;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    modport master (output multstart, multsgn, srca, srcb, lohi,
                    input  multresult, hi, lo, busy, done);
    modport slave  (input  multstart, multsgn, srca, srcb, lohi,
                    output multresult, hi, lo, busy, done);
endinterface

// File: rtl/mult_unit.sv
// mult_unit: iterative shift-add signed/unsigned multiplier with HI/LO result registers
module mult_unit #(parameter int WIDTH = 32) (
    input logic        clk,
    input logic        reset,
    mult_unit_if.slave m
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic [WIDTH-1:0]   ma;
    logic [WIDTH-1:0]   mb;
    // operand magnitudes; the most negative value maps to its unsigned magnitude
    always_comb begin
        ma = (m.multsgn && m.srca[WIDTH-1]) ? -m.srca : m.srca;
        mb = (m.multsgn && m.srcb[WIDTH-1]) ? -m.srcb : m.srcb;
    end
    assign m.multresult = m.lohi ? m.hi : m.lo;
    // control FSM and datapath: one multiplier bit per RUN cycle, sign fix, commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            m.hi   <= '0;
            m.lo   <= '0;
            m.busy <= 1'b0;
            m.done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    m.done <= 1'b0;
                    if (m.multstart) begin
                        state  <= RUN;
                        mcand  <= {{WIDTH{1'b0}}, ma};
                        mplier <= mb;
                        neg    <= m.multsgn & (m.srca[WIDTH-1] ^ m.srcb[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        m.busy <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    {m.hi, m.lo} <= neg ? -acc : acc;
                    m.done <= 1'b1;
                    m.busy <= 1'b0;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed self-checking bench for mult_unit
module tb_mult_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc;
    int   pulses;
    mult_unit_if #(.WIDTH(32)) bus ();
    mult_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .m(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.multstart = 1'b1;
        bus.srca = a;
        bus.srcb = b;
        bus.multsgn = s;
        @(posedge clk);
        @(negedge clk);
        bus.multstart = 1'b0;
    endtask
    task automatic run_to_done(output int n);
        n = 0;
        for (int i = 0; i < 200 && bus.done !== 1'b1; i++) begin
            if (bus.busy === 1'b1) n++;
            @(negedge clk);
        end
    endtask
    task automatic check_prod(input string tag, input logic [63:0] exp);
        check(tag, {bus.hi, bus.lo}, exp);
    endtask
    initial begin
        bus.multstart = 1'b0;
        bus.multsgn = 1'b0;
        bus.srca = '0;
        bus.srcb = '0;
        bus.lohi = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hilo", {bus.hi, bus.lo}, 64'h0);
        check("reset_flags", {62'h0, bus.busy, bus.done}, 64'h0);
        reset = 1'b0;
        @(negedge clk);
        start_op(32'd3, 32'd5, 1'b0);
        check("busy_rise", {63'h0, bus.busy}, 64'h1);
        run_to_done(cyc);
        check("u3x5_busy_cycles", 64'(cyc), 64'd33);
        check("u3x5_done", {63'h0, bus.done}, 64'h1);
        check_prod("u3x5", 64'h0000_0000_0000_000F);
        @(negedge clk);
        check("u3x5_done_one_cycle", {62'h0, bus.busy, bus.done}, 64'h0);
        start_op(32'hFFFF_FFFD, 32'd5, 1'b1);
        check_prod("hold_old_while_busy", 64'h0000_0000_0000_000F);
        run_to_done(cyc);
        check_prod("s_m3x5", 64'hFFFF_FFFF_FFFF_FFF1);
        @(negedge clk);
        start_op(32'hFFFF_FFFD, 32'd5, 1'b0);
        run_to_done(cyc);
        check_prod("u_m3x5", 64'h0000_0004_FFFF_FFF1);
        @(negedge clk);
        start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        run_to_done(cyc);
        check_prod("s_min_sq", 64'h4000_0000_0000_0000);
        @(negedge clk);
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_to_done(cyc);
        check_prod("u_max_sq", 64'hFFFF_FFFE_0000_0001);
        bus.lohi = 1'b1;
        #1 check("lohi_hi", 64'(bus.multresult), 64'hFFFF_FFFE);
        bus.lohi = 1'b0;
        #1 check("lohi_lo", 64'(bus.multresult), 64'h0000_0001);
        @(negedge clk);
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        bus.lohi = 1'b1;
        #1 check("lohi_hi_busy", 64'(bus.multresult), 64'hFFFF_FFFE);
        bus.lohi = 1'b0;
        #1 check("lohi_lo_busy", 64'(bus.multresult), 64'h0000_0001);
        @(negedge clk);
        run_to_done(cyc);
        check_prod("s_m1_sq", 64'h0000_0000_0000_0001);
        @(negedge clk);
        start_op(32'd3, 32'd5, 1'b0);
        repeat (9) @(negedge clk);
        start_op(32'd7, 32'd7, 1'b0);
        run_to_done(cyc);
        check_prod("ignored_start", 64'h0000_0000_0000_000F);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        check("no_second_done", 64'(pulses), 64'd0);
        start_op(32'd2, 32'd2, 1'b0);
        run_to_done(cyc);
        start_op(32'd7, 32'd7, 1'b0);
        check("back_to_back_busy", {62'h0, bus.busy, bus.done}, 64'h2);
        run_to_done(cyc);
        check("b2b_busy_cycles", 64'(cyc), 64'd33);
        check_prod("b2b_7x7", 64'h0000_0000_0000_0031);
        @(negedge clk);
        start_op(32'd2, 32'd3, 1'b0);
        run_to_done(cyc);
        check_prod("u2x3", 64'h0000_0000_0000_0006);
        @(negedge clk);
        start_op(32'd9, 32'd9, 1'b0);
        repeat (19) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset_hilo", {bus.hi, bus.lo}, 64'h0);
        check("async_reset_flags", {62'h0, bus.busy, bus.done}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {62'h0, bus.busy, bus.done}, 64'h0);
        start_op(32'd4, 32'd4, 1'b0);
        run_to_done(cyc);
        check_prod("u4x4", 64'h0000_0000_0000_0010);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
